// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode encoding and the
// mapping from mode / blink phase to the active-low LED level.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;
  localparam logic [1:0] MODE_FAST = 2'd3;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    logic [1:0] n;
    unique case (m)
      MODE_OFF:  n = MODE_ON;
      MODE_ON:   n = MODE_SLOW;
      MODE_SLOW: n = MODE_FAST;
      default:   n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic is_blink(input logic [1:0] m);
    return (m == MODE_SLOW) || (m == MODE_FAST);
  endfunction

  // LED pin is active-low; a blinking mode is lit while ph is 1.
  function automatic logic led_level(input logic [1:0] m, input logic ph);
    logic lvl;
    unique case (m)
      MODE_OFF:  lvl = 1'b1;
      MODE_ON:   lvl = 1'b0;
      default:   lvl = ~ph;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/led_ctrl_key_filter.sv
// Push-button front end: two-flop synchroniser, saturating debounce counter
// and a single registered pulse per accepted press.
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_flag
);

  localparam int            CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_PRE = CW'(CNT_MAX - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_flag;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_TOP) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Fires only on the single step into saturation, so a long hold gives one pulse.
      r_flag <= !r_sync2 && (r_cnt == CNT_PRE);
    end
  end

  assign key_flag = r_flag;

endmodule

// File: rtl/led_ctrl.sv
// LED mode controller: debounced key presses step OFF -> ON -> SLOW -> FAST,
// with a blink counter driving the registered active-low LED output.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CNT_MAX    = 999_999,
  parameter int BLINK_SLOW = 24_999_999,
  parameter int BLINK_FAST = 4_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  localparam int            BW       = $clog2(BLINK_SLOW);
  localparam logic [BW-1:0] SLOW_END = BW'(BLINK_SLOW - 1);
  localparam logic [BW-1:0] FAST_END = BW'(BLINK_FAST - 1);

  logic          w_flag;
  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic [BW-1:0] r_bcnt;
  logic [BW-1:0] w_bcnt_nxt;
  logic [BW-1:0] w_half_end;
  logic          r_ph;
  logic          w_ph_nxt;
  logic          r_led;
  logic          w_led_nxt;

  key_filter #(
    .CNT_MAX (CNT_MAX)
  ) u_key_filter (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .key_flag (w_flag)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_flag) begin
      w_mode_nxt = next_mode(r_mode);
    end
  end

  // A key press takes priority over a blink wrap so every blink mode starts lit.
  always_comb begin
    w_bcnt_nxt = '0;
    w_ph_nxt   = 1'b1;
    w_half_end = (r_mode == MODE_FAST) ? FAST_END : SLOW_END;
    if (!w_flag && is_blink(r_mode)) begin
      if (r_bcnt == w_half_end) begin
        w_bcnt_nxt = '0;
        w_ph_nxt   = ~r_ph;
      end else begin
        w_bcnt_nxt = r_bcnt + BW'(1);
        w_ph_nxt   = r_ph;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_bcnt <= '0;
      r_ph   <= 1'b1;
    end else begin
      r_bcnt <= w_bcnt_nxt;
      r_ph   <= w_ph_nxt;
    end
  end

  always_comb begin
    w_led_nxt = led_level(w_mode_nxt, w_ph_nxt);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_led <= 1'b1;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led_out  = r_led;
  assign mode     = r_mode;
  assign key_flag = w_flag;

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: a run-length / elapsed-time reference model
// queues the expected outputs per clock edge, a monitor compares them.
module tb_led_ctrl;

  localparam int CNT_MAX = 20;
  localparam int SLOW    = 10;
  localparam int FAST    = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_in  = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  always #5 sys_clk = ~sys_clk;

  led_ctrl #(
    .CNT_MAX    (CNT_MAX),
    .BLINK_SLOW (SLOW),
    .BLINK_FAST (FAST)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode     (mode),
    .key_flag (key_flag)
  );

  typedef struct {
    int   edge_no;
    logic flag;
    logic [1:0] mode;
    logic led;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: low-run lengths of the sampled key, mode, time of last mode change.
  int   run_m1 = 0;
  int   run_m2 = 0;
  int   m_mode = 0;
  int   m_chg  = 0;
  int   m_edge = 0;
  logic m_flag_prev = 1'b0;
  logic m_led = 1'b1;

  function automatic logic led_of(input int md, input int dt);
    logic l;
    case (md)
      0:       l = 1'b1;
      1:       l = 1'b0;
      2:       l = ((dt / SLOW) % 2 == 0) ? 1'b0 : 1'b1;
      default: l = ((dt / FAST) % 2 == 0) ? 1'b0 : 1'b1;
    endcase
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req,
                       input int edge_no);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, req);
    end
  endtask

  // Drive one clock edge's inputs and queue what the DUT must show after that edge.
  task automatic step(input logic key, input logic rst);
    exp_t e;
    int   run_k;
    logic flag;
    key_in  = key;
    sys_rst = rst;
    if (rst) begin
      flag   = 1'b0;
      m_mode = 0;
      m_chg  = m_edge;
      run_m1 = 0;
      run_k  = 0;
    end else begin
      flag = (run_m2 == CNT_MAX);
      if (m_flag_prev) begin
        m_mode = (m_mode + 1) % 4;
        m_chg  = m_edge;
      end
      run_k = key ? 0 : ((run_m1 < CNT_MAX + 4) ? run_m1 + 1 : run_m1);
    end
    run_m2      = run_m1;
    run_m1      = run_k;
    m_flag_prev = flag;
    m_led       = led_of(m_mode, m_edge - m_chg);
    e.edge_no   = m_edge;
    e.flag      = flag;
    e.mode      = 2'(m_mode);
    e.led       = m_led;
    exp_q.push_back(e);
    m_edge++;
    @(posedge sys_clk);
    #1;
  endtask

  exp_t mon_e;
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("key_flag", {31'b0, key_flag}, {31'b0, mon_e.flag}, mon_e.edge_no);
      check("mode",     {30'b0, mode},     {30'b0, mon_e.mode}, mon_e.edge_no);
      check("led_out",  {31'b0, led_out},  {31'b0, mon_e.led},  mon_e.edge_no);
    end
  end

  initial begin
    int   steps;
    int   len;
    logic v;

    // Reset held with the key already down, then keep holding.
    repeat (3) step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);

    // Clean long press.
    repeat (100) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);

    // Bounce every 5 cycles: never long enough to register.
    for (int i = 0; i < 200; i++) step(((i / 5) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0);

    // Into FAST, then reset while in the dark phase.
    repeat (30) step(1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0);
    for (int i = 0; i < 20 && !(m_mode == 3 && m_led == 1'b1); i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);

    // Press train with varying gaps so key_flag lands on every blink phase.
    for (int g = 0; g < 16; g++) begin
      repeat (25) step(1'b0, 1'b0);
      repeat (g + 1) step(1'b1, 1'b0);
    end

    // Random key runs with rare resets.
    steps = 0;
    while (steps < 2000) begin
      v   = 1'($urandom_range(0, 1));
      len = (v == 1'b0) ? int'($urandom_range(1, 35)) : int'($urandom_range(1, 15));
      for (int j = 0; j < len; j++) step(v, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      steps += len;
    end
    repeat (5) step(1'b1, 1'b0);

    @(negedge sys_clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0, m_edge);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
